// File: rtl/quad_pkg.sv
// quad_pkg: shared types and constants for the quadrature transmitter.
// FSM state encoding, 2-bit Gray phase encodings ({a,b}), direction
// constants and the one-step phase advance function.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {enc_a, enc_b} levels for the four quadrature positions.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // One Gray-code step: increment walks 00->10->11->01->00, decrement reverses.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = (dir == DIR_INC) ? PH_10 : PH_01;
      PH_10:   nxt = (dir == DIR_INC) ? PH_11 : PH_00;
      PH_11:   nxt = (dir == DIR_INC) ? PH_01 : PH_10;
      default: nxt = (dir == DIR_INC) ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// quad_phase_seq: 2-bit Gray phase register. Advances one position in the
// requested direction whenever i_advance is high. Only reset re-zeroes it,
// so the emitted position stays continuous across commands.
module quad_phase_seq
  import quad_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_advance,
  input  logic       i_dir,
  output logic [1:0] o_phase
);

  logic [1:0] r_phase;

  // Phase register: hold, or step once per advance strobe.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_phase <= PH_00;
    end else if (i_advance) begin
      r_phase <= phase_step(r_phase, i_dir);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/quad_gen.sv
// quad_gen: quadrature transmitter. Emits enc_a/enc_b as if a rotary encoder
// were turned cmd_steps positions in direction cmd_dir, one transition every
// cmd_period clocks (0 behaves as 1).
// Optional build macro QUAD_BOUNCE_EN adds contact chatter of BOUNCE_CYCLES
// clocks on the changing line after each nominal transition.
module quad_gen
  import quad_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int DIV_WIDTH   = 16
`ifdef QUAD_BOUNCE_EN
  ,
  parameter int BOUNCE_CYCLES = 5
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_dir,
  input  logic [COUNT_WIDTH-1:0] i_cmd_steps,
  input  logic [DIV_WIDTH-1:0]   i_cmd_period,
  input  logic                   i_cmd_abort,
  output logic                   o_enc_a,
  output logic                   o_enc_b,
  output logic                   o_busy,
  output logic                   o_done
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_tick;
  logic                   r_dir;
  logic [DIV_WIDTH-1:0]   r_period;
  logic [DIV_WIDTH-1:0]   r_timer;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [DIV_WIDTH-1:0]   w_period_eff;
  logic [1:0]             w_phase;

  assign w_period_eff = (i_cmd_period == '0) ? DIV_WIDTH'(1) : i_cmd_period;

  // Timer terminal count is 1: loaded with P at accept, the transition lands
  // exactly P edges later, and each reload repeats that spacing.
  assign w_tick = (r_state == RUN) && (r_timer == DIV_WIDTH'(1));

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the final transition and RUN->DONE share one edge.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (i_cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((w_tick && (r_remaining == COUNT_WIDTH'(1))) || i_cmd_abort) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, step timer and remaining-step counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dir       <= DIR_DEC;
      r_period    <= '0;
      r_timer     <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_dir       <= i_cmd_dir;
      r_period    <= w_period_eff;
      r_timer     <= w_period_eff;
      r_remaining <= i_cmd_steps;
    end else if (r_state == RUN) begin
      if (w_tick) begin
        r_timer     <= r_period;
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
      end else begin
        r_timer <= r_timer - DIV_WIDTH'(1);
      end
    end
  end

  quad_phase_seq u_phase_seq (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_advance (w_tick),
    .i_dir     (r_dir),
    .o_phase   (w_phase)
  );

`ifdef QUAD_BOUNCE_EN
  localparam int             BW   = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BW-1:0]  BC_L = BW'(BOUNCE_CYCLES);

  logic [BW-1:0] r_bk;     // clocks since last nominal transition, saturating
  logic [BW-1:0] w_bk_nxt;
  logic [1:0]    r_bmask;  // which line changed on the last transition
  logic [1:0]    r_enc;

  assign w_bk_nxt = (r_bk == BC_L) ? r_bk : r_bk + BW'(1);

  // Chatter shaper: new level on even k, old level on odd k, k < BOUNCE_CYCLES.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bk    <= BC_L;
      r_bmask <= 2'b00;
      r_enc   <= PH_00;
    end else if (w_tick) begin
      r_bk    <= '0;
      r_bmask <= w_phase ^ phase_step(w_phase, r_dir);
      r_enc   <= phase_step(w_phase, r_dir);
    end else begin
      r_bk  <= w_bk_nxt;
      r_enc <= ((w_bk_nxt < BC_L) && w_bk_nxt[0]) ? (w_phase ^ r_bmask) : w_phase;
    end
  end

  assign o_enc_a = r_enc[1];
  assign o_enc_b = r_enc[0];
`else
  assign o_enc_a = w_phase[1];
  assign o_enc_b = w_phase[0];
`endif

  assign o_cmd_ready = (r_state == IDLE);
  assign o_busy      = ~o_cmd_ready;
  assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: self-checking bench for quad_gen. A position/time model
// predicts every output each cycle; directed sequences pin literal values.
module tb_quad_gen;

  localparam int CW = 8;
  localparam int DW = 16;
  localparam int BC = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_steps = '0;
  logic [DW-1:0] cmd_period = '0;
  logic          cmd_abort = 1'b0;
  logic          enc_a, enc_b, busy, done;

  always #5 clk = ~clk;

  quad_gen #(.COUNT_WIDTH(CW), .DIV_WIDTH(DW)) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_dir    (cmd_dir),
    .i_cmd_steps  (cmd_steps),
    .i_cmd_period (cmd_period),
    .i_cmd_abort  (cmd_abort),
    .o_enc_a      (enc_a),
    .o_enc_b      (enc_b),
    .o_busy       (busy),
    .o_done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Position 0..3 maps to {a,b} = 00,10,11,01.
  function automatic logic [1:0] ab_of(input int pos);
    case (pos)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Model: a command accepted at edge E0 moves the position at E0+k*P,
  // k=1..N, unless an abort was seen first; done is the cycle after the end.
  int m_pos = 0, m_prev = 0, m_since = BC, m_t = 0, m_cnt = 0, m_p = 1, m_n = 0;
  bit m_run = 0, m_done = 0, m_dir = 0;

  always @(posedge clk or negedge reset) begin : model
    int pos, prev, since, t, cnt;
    bit run, dn;
    if (!reset) begin
      m_pos <= 0; m_prev <= 0; m_since <= BC; m_t <= 0; m_cnt <= 0;
      m_run <= 0; m_done <= 0;
    end else begin
      pos = m_pos; prev = m_prev; t = m_t; cnt = m_cnt; run = m_run; dn = m_done;
      since = (m_since < BC) ? m_since + 1 : m_since;
      if (dn) begin
        dn = 0;
      end else if (run) begin
        t++;
        if (t % m_p == 0) begin
          prev = pos;
          pos = (pos + (m_dir ? 1 : 3)) % 4;
          cnt++;
          since = 0;
        end
        if (cnt == m_n || cmd_abort) begin
          run = 0;
          dn = 1;
        end
      end else if (cmd_valid) begin
        m_dir <= cmd_dir;
        m_p   <= (cmd_period == 0) ? 1 : int'(cmd_period);
        m_n   <= int'(cmd_steps);
        t = 0;
        cnt = 0;
        if (cmd_steps == 0) dn = 1;
        else run = 1;
      end
      m_pos <= pos; m_prev <= prev; m_since <= since; m_t <= t; m_cnt <= cnt;
      m_run <= run; m_done <= dn;
    end
  end

  function automatic logic [1:0] exp_ab();
`ifdef QUAD_BOUNCE_EN
    if (m_since < BC && (m_since % 2) == 1) return ab_of(m_prev);
`endif
    return ab_of(m_pos);
  endfunction

  bit chk_en = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("enc_ab", {30'd0, enc_a, enc_b}, {30'd0, exp_ab()});
      check("cmd_ready", cmd_ready, !(m_run || m_done));
      check("busy", busy, (m_run || m_done));
      check("done", done, m_done);
    end
  end

  int off = 0;

  task automatic wait_to(input int n);
    repeat (n - off) @(posedge clk);
    #1;
    off = n;
  endtask

  // Present one command once ready; returns just after the accepting edge E0.
  task automatic send(input bit d, input int steps, input int period);
    int n = 0;
    while (!cmd_ready && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", cmd_ready, 1);
    cmd_valid = 1; cmd_dir = d; cmd_steps = CW'(steps); cmd_period = DW'(period);
    @(posedge clk); #1;
    cmd_valid = 0;
    off = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    chk_en = 1;
    check("rst_ready", cmd_ready, 1);
    check("rst_ab", {enc_a, enc_b}, 2'b00);
    check("rst_done", done, 0);

    // Increment 4 at period 3.
    send(1, 4, 3);
    wait_to(3);  check("t1_e3", {enc_a, enc_b}, 2'b10);
    wait_to(6);  check("t1_e6", {enc_a, enc_b}, 2'b11);
    wait_to(9);  check("t1_e9", {enc_a, enc_b}, 2'b01);
    wait_to(11); check("t1_done_early", done, 0);
    wait_to(12); check("t1_e12", {enc_a, enc_b}, 2'b00); check("t1_done", done, 1);
    wait_to(13); check("t1_ready", cmd_ready, 1); check("t1_done_off", done, 0);

    // Decrement 2 with period 0 (behaves as 1).
    send(0, 2, 0);
    wait_to(1); check("t2_e1", {enc_a, enc_b}, 2'b01);
    wait_to(2); check("t2_e2", {enc_a, enc_b}, 2'b11); check("t2_done", done, 1);
    wait_to(3); check("t2_ready", cmd_ready, 1);

    // Zero steps: done at the accepting edge, no edge emitted.
    send(1, 0, 100);
    check("t3_done", done, 1); check("t3_ab", {enc_a, enc_b}, 2'b11);
    wait_to(1); check("t3_ready", cmd_ready, 1); check("t3_done_off", done, 0);

    // Reset mid-command; a command offered while busy must be ignored.
    send(1, 8, 10);
    wait_to(5);
    cmd_valid = 1; cmd_dir = 0; cmd_steps = 3; cmd_period = 1;
    wait_to(8);  check("t5_busy", busy, 1);
    cmd_valid = 0;
    wait_to(10); check("t5_e10", {enc_a, enc_b}, 2'b01);
    wait_to(15);
    reset = 0;
    #1;
    check("t5_async_ab", {enc_a, enc_b}, 2'b00);
    check("t5_no_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    check("t5_ready", cmd_ready, 1);

    // Abort after two transitions.
    send(1, 255, 10);
    wait_to(10); check("t4_e10", {enc_a, enc_b}, 2'b10);
    wait_to(20); check("t4_e20", {enc_a, enc_b}, 2'b11);
    wait_to(25); cmd_abort = 1;
    wait_to(26); cmd_abort = 0;
    check("t4_done", done, 1); check("t4_ab", {enc_a, enc_b}, 2'b11);
    wait_to(27); check("t4_ready", cmd_ready, 1);
    wait_to(40); check("t4_hold", {enc_a, enc_b}, 2'b11);

    // Maximum step count: 255 decrements = net 3 back from 11 -> 01.
    send(0, 255, 1);
    wait_to(254); check("max_steps_early", done, 0);
    wait_to(255); check("max_steps_done", done, 1); check("max_steps_ab", {enc_a, enc_b}, 2'b01);

    // Abort on a transition edge: that transition still happens.
    send(1, 5, 4);
    wait_to(3); cmd_abort = 1;
    wait_to(4); cmd_abort = 0;
    check("abort_edge_ab", {enc_a, enc_b}, 2'b00); check("abort_edge_done", done, 1);

    // Maximum period.
    send(1, 1, 65535);
    wait_to(65534); check("max_per_early", done, 0); check("max_per_ab0", {enc_a, enc_b}, 2'b00);
    wait_to(65535); check("max_per_done", done, 1); check("max_per_ab", {enc_a, enc_b}, 2'b10);

    // Randomized traffic, including aborts and commands offered while busy.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_dir    = 1'($urandom_range(0, 1));
      cmd_steps  = CW'($urandom_range(0, 12));
      cmd_period = DW'($urandom_range(0, 4));
      cmd_abort  = ($urandom_range(0, 15) == 0);
    end
    cmd_valid = 0; cmd_abort = 0;
    repeat (60) @(posedge clk);
    #1;
    check("final_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
